// File: rtl/csa_pkg.sv
// Shared types and constants for the carry-save accumulator.
package csa_pkg;
  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ACC_WIDTH = 16;
  localparam int DEF_CPA_CHUNK = 4;

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/csa_3to2.sv
// Bitwise 3:2 compressor: one full adder per bit, no carry chain.
module csa_3to2 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] m
);
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ c[i];
    assign m[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end
endmodule

// File: rtl/csa_accum.sv
// Streaming accumulator: carry-save running total per frame, resolved by a
// chunked carry-propagate pass, one binary result per frame.
module csa_accum
  import csa_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CPA_CHUNK = DEF_CPA_CHUNK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_overflow
);
  localparam int K  = ACC_WIDTH / CPA_CHUNK;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  state_t state, state_nx;

  logic [ACC_WIDTH-1:0] s_reg, c_reg, x, s_nx, m_nx;
  logic [CNT_W-1:0]     count;
  logic                 ovf, cy, co, chunk_last;
  logic [CW-1:0]        chunk;
  logic [CPA_CHUNK-1:0] csum;
  logic [K-1:0][CPA_CHUNK-1:0] s_ch, c_ch, res, res_nx;

  assign in_ready = (state == ACCUM);
  assign x        = ACC_WIDTH'(in_data);

  csa_3to2 #(.W(ACC_WIDTH)) u_csa (
    .a(s_reg), .b(c_reg), .c(x), .s(s_nx), .m(m_nx)
  );

  // Chunk view of the redundant pair; one chunk is resolved per cycle.
  assign s_ch       = s_reg;
  assign c_ch       = c_reg;
  assign chunk_last = (chunk == CW'(K - 1));
  assign {co, csum} = {1'b0, s_ch[chunk]} + {1'b0, c_ch[chunk]}
                    + {{CPA_CHUNK{1'b0}}, cy};

  always_comb begin
    res_nx        = res;
    res_nx[chunk] = csum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM:   if (in_valid && in_last) state_nx = RESOLVE;
      RESOLVE: if (chunk_last)          state_nx = OUTPUT;
      OUTPUT:  if (out_ready)           state_nx = ACCUM;
      default:                          state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg        <= '0;
      c_reg        <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      cy           <= 1'b0;
      chunk        <= '0;
      res          <= '0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: if (in_valid) begin
          s_reg <= s_nx;
          // The majority MSB has no place left to shift into: it is a lost 2^ACC_WIDTH.
          c_reg <= {m_nx[ACC_WIDTH-2:0], 1'b0};
          ovf   <= ovf | m_nx[ACC_WIDTH-1];
          if (count != CNT_MAX) count <= count + CNT_W'(1);
          if (in_last) begin
            cy    <= 1'b0;
            chunk <= '0;
          end
        end
        RESOLVE: begin
          res   <= res_nx;
          cy    <= co;
          chunk <= chunk + CW'(1);
          if (chunk_last) begin
            out_sum      <= res_nx;
            out_overflow <= ovf | co;
            out_count    <= count;
            out_valid    <= 1'b1;
          end
        end
        OUTPUT: if (out_ready) begin
          s_reg     <= '0;
          c_reg     <= '0;
          count     <= '0;
          ovf       <= 1'b0;
          cy        <= 1'b0;
          out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_accum.sv
// Self-checking bench for csa_accum: directed table, hand-written corner
// sequences and random frames against an arithmetic reference.
module tb_csa_accum;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_overflow;
  logic [15:0] out_sum;
  logic [7:0]  out_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  csa_accum #(.WIDTH(8), .ACC_WIDTH(16), .CPA_CHUNK(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          n;
    logic [7:0]  val;
    logic [15:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Presents one operand from a negedge; returns the cycle index it was accepted in.
  task automatic send(input logic [7:0] d, input logic last, output int acc_cyc);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    acc_cyc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get_result(input string nm, input logic [15:0] es, input logic [7:0] ec,
                            input logic eo, input int hold, input bit hold_chk,
                            output int vld_cyc);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    vld_cyc = cyc;
    if (!out_valid) chk({nm, "_timeout"}, 0, 1);
    for (int h = 0; h < hold; h++) begin
      if (hold_chk) begin
        chk({nm, "_hold_sum"}, out_sum, es);
        chk({nm, "_hold_cnt"}, out_count, ec);
        chk({nm, "_hold_vld"}, out_valid, 1);
        chk({nm, "_hold_rdy"}, in_ready, 0);
      end
      @(negedge clk);
    end
    chk({nm, "_sum"}, out_sum, es);
    chk({nm, "_cnt"}, out_count, ec);
    chk({nm, "_ovf"}, out_overflow, eo);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int a, v;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

    tbl[0] = '{257, 8'd255, 16'd65535, 8'd255, 1'b0};
    tbl[1] = '{258, 8'd255, 16'd254,   8'd255, 1'b1};
    tbl[2] = '{1,   8'hAB,  16'd171,   8'd1,   1'b0};
    tbl[3] = '{4,   8'd100, 16'd400,   8'd4,   1'b0};
    tbl[4] = '{1,   8'd0,   16'd0,     8'd1,   1'b0};

    repeat (3) @(negedge clk);
    chk("rst_vld", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_cnt", out_count, 0);
    chk("rst_ovf", out_overflow, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", in_ready, 1);

    // 3,5,7 with exact latency from acceptance of the last operand
    send(8'd3, 1'b0, a);
    send(8'd5, 1'b0, a);
    send(8'd7, 1'b1, a);
    get_result("f357", 16'd15, 8'd3, 1'b0, 0, 1'b0, v);
    chk("f357_latency", v - a, 5);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < tbl[i].n; j++) send(tbl[i].val, j == tbl[i].n - 1, a);
      get_result($sformatf("tbl%0d", i), tbl[i].sum, tbl[i].cnt, tbl[i].ovf, 0, 1'b0, v);
    end

    // Backpressure, then a fresh frame must carry no residue
    send(8'd10, 1'b0, a);
    send(8'd20, 1'b1, a);
    get_result("bp", 16'd30, 8'd2, 1'b0, 10, 1'b1, v);
    send(8'd1, 1'b0, a);
    send(8'd2, 1'b1, a);
    get_result("after_bp", 16'd3, 8'd2, 1'b0, 0, 1'b0, v);

    // Operands offered during RESOLVE/OUTPUT must be ignored
    send(8'hAB, 1'b1, a);
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    @(negedge clk);
    chk("ign_rdy", in_ready, 0);
    get_result("ign", 16'd171, 8'd1, 1'b0, 2, 1'b0, v);
    in_valid = 1'b0; in_last = 1'b0;
    send(8'd4, 1'b1, a);
    get_result("after_ign", 16'd4, 8'd1, 1'b0, 0, 1'b0, v);

    // Reset in the second RESOLVE cycle
    send(8'd50, 1'b0, a);
    send(8'd60, 1'b1, a);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_vld", out_valid, 0);
    chk("midrst_sum", out_sum, 0);
    chk("midrst_cnt", out_count, 0);
    chk("midrst_ovf", out_overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'd9, 1'b1, a);
    get_result("post_rst", 16'd9, 8'd1, 1'b0, 0, 1'b0, v);

    // Random frames against an arithmetic reference
    for (int f = 0; f < 12; f++) begin
      int n;
      longint total;
      n = $urandom_range(1, 300);
      total = 0;
      for (int j = 0; j < n; j++) begin
        logic [7:0] d;
        d = (f % 3 == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
        total += d;
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        send(d, j == n - 1, a);
      end
      get_result($sformatf("rnd%0d", f), 16'(total), (n > 255) ? 8'd255 : 8'(n),
                 total >= 65536, $urandom_range(0, 3), 1'b0, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
